// File: rtl/weight_load_scheduler.sv
// Sequences weight loads from NUM_FILTERS per-filter ROMs into the conv datapath, with a per-filter timeout.
// Define WLS_PARALLEL_EN to pulse all ROMs at once and wait for the whole batch under a single timeout.
module weight_load_scheduler #(
  parameter  int unsigned NUM_FILTERS    = 3,
  parameter  int unsigned TIMEOUT_CYCLES = 64,
  localparam int unsigned FID_W          = (NUM_FILTERS > 1) ? $clog2(NUM_FILTERS) : 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   conv_idle,
  output logic [NUM_FILTERS-1:0] rom_read_enable,
  input  logic [NUM_FILTERS-1:0] rom_weight_valid,
  output logic [FID_W-1:0]       cur_filter,
  output logic [NUM_FILTERS-1:0] loaded_mask,
  output logic                   busy,
  output logic                   weights_ready,
  output logic                   done,
  output logic                   timeout_err
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ISSUE = 3'd1,
    WAIT  = 3'd2,
    DONE  = 3'd3,
    ERR   = 3'd4
  } state_t;

  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [FID_W-1:0]       cur_d;
  logic [NUM_FILTERS-1:0] mask_d;
  logic                   ready_d;
  logic                   err_d;
  logic [NUM_FILTERS-1:0] rd_en_d;
  logic                   busy_d;
  logic                   done_d;
  logic                   timed_out;

  assign timed_out = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  // State register; outputs are registered from the next-state decode so they line up with the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= IDLE;
      cnt_q           <= '0;
      cur_filter      <= '0;
      loaded_mask     <= '0;
      weights_ready   <= 1'b0;
      timeout_err     <= 1'b0;
      rom_read_enable <= '0;
      busy            <= 1'b0;
      done            <= 1'b0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      cur_filter      <= cur_d;
      loaded_mask     <= mask_d;
      weights_ready   <= ready_d;
      timeout_err     <= err_d;
      rom_read_enable <= rd_en_d;
      busy            <= busy_d;
      done            <= done_d;
    end
  end

  // Next-state and next-output decode.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cur_d   = cur_filter;
    mask_d  = loaded_mask;
    ready_d = weights_ready;
    err_d   = timeout_err;
    rd_en_d = '0;
    busy_d  = 1'b0;
    done_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start && conv_idle) begin
          mask_d  = '0;
          ready_d = 1'b0;
          err_d   = 1'b0;
          cur_d   = '0;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        cnt_d   = '0;
        state_d = WAIT;
      end
      WAIT: begin
        cnt_d = cnt_q + CNT_W'(1);
`ifdef WLS_PARALLEL_EN
        mask_d = loaded_mask | rom_weight_valid;
        if (&mask_d) begin
          state_d = DONE;
        end else if (timed_out) begin
          state_d = ERR;
        end
`else
        // Only the filter being loaded may advance the sequence; a late timeout loses to a valid.
        if (rom_weight_valid[cur_filter]) begin
          mask_d[cur_filter] = 1'b1;
          if (cur_filter == FID_W'(NUM_FILTERS - 1)) begin
            state_d = DONE;
          end else begin
            cur_d   = cur_filter + FID_W'(1);
            state_d = ISSUE;
          end
        end else if (timed_out) begin
          state_d = ERR;
        end
`endif
      end
      DONE: begin
        ready_d = 1'b1;
        state_d = IDLE;
      end
      ERR: begin
        err_d   = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (state_d == ISSUE) begin
`ifdef WLS_PARALLEL_EN
      rd_en_d = '1;
`else
      rd_en_d = NUM_FILTERS'(1) << cur_d;
`endif
    end
    busy_d = (state_d == ISSUE) || (state_d == WAIT) || (state_d == DONE);
    done_d = (state_d == DONE);
  end

endmodule

// File: tb/tb_weight_load_scheduler.sv
// Scoreboard bench for weight_load_scheduler: expected read pulses, done and timeout events are queued at
// start time and a monitor pops and compares them as the DUT produces them.
module tb_weight_load_scheduler;

  localparam int unsigned NF = 3;
  localparam int unsigned TO = 64;
  localparam int EV_PULSE = 0;
  localparam int EV_DONE  = 1;
  localparam int EV_ERR   = 2;
`ifdef WLS_PARALLEL_EN
  localparam int EXP_LAST_FID = 0;
  localparam int EXP_ERR_FID  = 0;
`else
  localparam int EXP_LAST_FID = NF - 1;
  localparam int EXP_ERR_FID  = 1;
`endif

  typedef struct {
    int          kind;
    int          cyc;
    logic [NF-1:0] val;
    logic [NF-1:0] mask;
  } evt_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          conv_idle = 1'b0;
  logic [NF-1:0] rom_read_enable;
  logic [NF-1:0] rom_weight_valid = '0;
  logic [1:0]    cur_filter;
  logic [NF-1:0] loaded_mask;
  logic          busy, weights_ready, done, timeout_err;

  evt_t exp_q[$];
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;
  int   lat[NF];
  bit   dead[NF];
  int   cd[NF];
  int   spur_cyc = -1;
  bit   err_prev = 1'b0;
  bit   done_prev = 1'b0;

  weight_load_scheduler #(.NUM_FILTERS(NF), .TIMEOUT_CYCLES(TO)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .start           (start),
    .conv_idle       (conv_idle),
    .rom_read_enable (rom_read_enable),
    .rom_weight_valid(rom_weight_valid),
    .cur_filter      (cur_filter),
    .loaded_mask     (loaded_mask),
    .busy            (busy),
    .weights_ready   (weights_ready),
    .done            (done),
    .timeout_err     (timeout_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void push(input int kind, input int c, input logic [NF-1:0] v, input logic [NF-1:0] m);
    evt_t e;
    e.kind = kind; e.cyc = c; e.val = v; e.mask = m;
    exp_q.push_back(e);
  endfunction

  // Expected event list for a load accepted in cycle t0; dead_idx < 0 means every ROM answers.
  function automatic void push_load(input int t0, input int dead_idx);
    int            t;
    int            mx;
    logic [NF-1:0] m;
    t = t0 + 1;
    m = '0;
`ifdef WLS_PARALLEL_EN
    push(EV_PULSE, t, '1, '0);
    if (dead_idx >= 0) begin
      m = '1;
      m[dead_idx] = 1'b0;
      push(EV_ERR, t + TO + 2, '0, m);
    end else begin
      mx = 0;
      for (int i = 0; i < NF; i++) if (lat[i] > mx) mx = lat[i];
      push(EV_DONE, t + mx + 1, '0, '1);
    end
`else
    mx = 0;
    for (int i = 0; i < NF; i++) begin
      if (i == dead_idx) begin
        push(EV_PULSE, t, NF'(1) << i, m);
        push(EV_ERR, t + TO + 2, '0, m);
        return;
      end
      push(EV_PULSE, t, NF'(1) << i, m);
      m[i] = 1'b1;
      t = t + lat[i] + 1;
    end
    push(EV_DONE, t, '0, m);
`endif
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h, required %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_evt(input int kind, input logic [NF-1:0] v, input logic [NF-1:0] m);
    evt_t e;
    n_chk++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL unexpected_event: actual kind=%0d cyc=%0d val=%b mask=%b, required no event", kind, cyc, v, m);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != kind || e.cyc != cyc || e.val !== v || e.mask !== m) begin
        n_fail++;
        $display("FAIL event: actual kind=%0d cyc=%0d val=%b mask=%b, required kind=%0d cyc=%0d val=%b mask=%b",
                 kind, cyc, v, m, e.kind, e.cyc, e.val, e.mask);
      end
    end
  endtask

  // ROM model: valid pulse lat[i] cycles after a read pulse; dead ROMs never answer.
  always @(negedge clk) begin
    logic [NF-1:0] v;
    v = '0;
    for (int i = 0; i < NF; i++) begin
      if (!rst_n) cd[i] = 0;
      else if (cd[i] > 0) begin
        cd[i] = cd[i] - 1;
        if (cd[i] == 0) v[i] = 1'b1;
      end else if (rom_read_enable[i] && !dead[i]) cd[i] = lat[i];
    end
    if (rst_n && cyc == spur_cyc) v[2] = 1'b1;
    rom_weight_valid = v;
  end

  // Monitor: every DUT event must match the head of the expected queue.
  always @(negedge clk) begin
    if (rst_n) begin
      if (done_prev) chk("ready_after_done", 32'(weights_ready), 32'd1);
      if (rom_read_enable != '0) check_evt(EV_PULSE, rom_read_enable, loaded_mask);
      if (done) check_evt(EV_DONE, '0, loaded_mask);
      if (timeout_err && !err_prev) check_evt(EV_ERR, '0, loaded_mask);
      err_prev  = timeout_err;
      done_prev = done;
    end else begin
      err_prev  = 1'b0;
      done_prev = 1'b0;
    end
  end

  task automatic wait_cyc(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic do_start(output int t0, input int dead_idx);
    @(negedge clk);
    start = 1'b1;
    conv_idle = 1'b1;
    t0 = cyc;
    push_load(t0, dead_idx);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_drain(input string name, input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    n_chk++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL %s: actual %0d events pending after %0d cycles, required 0", name, exp_q.size(), budget);
      exp_q.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int t0;
    for (int i = 0; i < NF; i++) begin
      lat[i] = 5;
      dead[i] = 1'b0;
      cd[i] = 0;
    end

    repeat (3) @(negedge clk);
    chk("reset_outputs", 32'({rom_read_enable, loaded_mask, cur_filter, busy, weights_ready, done, timeout_err}), 32'd0);
    rst_n = 1'b1;

    // Baseline load, L=5 on every ROM.
    do_start(t0, -1);
    wait_drain("normal_load", 40);
    chk("normal_ready", 32'(weights_ready), 32'd1);
    chk("normal_busy", 32'(busy), 32'd0);
    chk("normal_cur_filter", 32'(cur_filter), 32'(EXP_LAST_FID));

    // start while the datapath is busy must be dropped.
    @(negedge clk);
    start = 1'b1;
    conv_idle = 1'b0;
    @(negedge clk);
    start = 1'b0;
    chk("not_idle_busy", 32'(busy), 32'd0);
    repeat (3) @(negedge clk);
    chk("not_idle_busy_later", 32'(busy), 32'd0);
    chk("not_idle_ready_kept", 32'(weights_ready), 32'd1);
    do_start(t0, -1);
    wait_drain("after_not_idle", 40);

    // Spurious valid on another ROM and extra starts mid-load.
    do_start(t0, -1);
`ifndef WLS_PARALLEL_EN
    spur_cyc = t0 + 3;
`endif
    conv_idle = 1'b0;
    wait_cyc(t0 + 3);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_cyc(t0 + 5);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_drain("spurious_and_restart", 40);
    spur_cyc = -1;

    // ROM 1 never answers.
    dead[1] = 1'b1;
    do_start(t0, 1);
    wait_drain("timeout", 100);
    chk("timeout_ready", 32'(weights_ready), 32'd0);
    chk("timeout_sticky", 32'(timeout_err), 32'd1);
    chk("timeout_busy", 32'(busy), 32'd0);
    chk("timeout_cur_filter", 32'(cur_filter), 32'(EXP_ERR_FID));
    dead[1] = 1'b0;
    do_start(t0, -1);
    chk("timeout_cleared", 32'(timeout_err), 32'd0);
    wait_drain("after_timeout", 40);

    // Staggered ROM latencies.
    lat[0] = 5; lat[1] = 3; lat[2] = 9;
    do_start(t0, -1);
    wait_drain("staggered", 40);
    chk("staggered_ready", 32'(weights_ready), 32'd1);
    for (int i = 0; i < NF; i++) lat[i] = 5;

    // Asynchronous reset in cycle 10 of a load.
    do_start(t0, -1);
    wait_cyc(t0 + 10);
    #1 rst_n = 1'b0;
    #1;
    chk("async_reset_outputs", 32'({rom_read_enable, loaded_mask, cur_filter, busy, weights_ready, done, timeout_err}), 32'd0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    chk("post_reset_busy", 32'(busy), 32'd0);
    chk("post_reset_ready", 32'(weights_ready), 32'd0);
    chk("post_reset_mask", 32'(loaded_mask), 32'd0);

    do_start(t0, -1);
    wait_drain("recovery_load", 40);
    chk("recovery_ready", 32'(weights_ready), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/weight_load_scheduler.md
Name: weight_load_scheduler

Overview:
Sequences weight loading from the per-filter weight ROM instances into the conv datapath, one filter at a time.
- Issues a one-cycle read pulse to each ROM, waits for that ROM's one-cycle valid pulse, then advances to the next filter.
- Tracks which filters are loaded and raises weights_ready when all are loaded.
- Detects a ROM that never responds, using a per-filter timeout.
- Sits between the layer control FSM (start/done) and the bank of NUM_FILTERS weight ROMs.

Parameters:
- NUM_FILTERS, 3: number of weight ROM instances (one per filter), ≥1.
- TIMEOUT_CYCLES, 64: maximum WAIT cycles per filter (per batch in parallel mode) before error. Must exceed ROM latency (INPUT_CHANNELS·KERNEL_SIZE²+2).
- FID_W, max(1,$clog2(NUM_FILTERS)): filter index width (localparam).

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  request to load all filters; sampled only in IDLE
- conv_idle  in  1  conv datapath not consuming weights; start accepted only when high
- rom_read_enable  out  NUM_FILTERS  one-cycle read pulse, bit i to ROM i
- rom_weight_valid  in  NUM_FILTERS  one-cycle valid pulse, bit i from ROM i
- cur_filter  out  FID_W  index of filter being loaded
- loaded_mask  out  NUM_FILTERS  bit i set once ROM i reported valid in current load
- busy  out  1  high in ISSUE/WAIT/DONE
- weights_ready  out  1  level; all filters loaded in current load
- done  out  1  one-cycle pulse on load completion
- timeout_err  out  1  sticky; cleared by next accepted start

Behaviour:
- Reset is asynchronous, active-low, on rst_n; clock is clk. In reset:
  - state=IDLE; all outputs 0; cur_filter=0; wait counter=0.
  - Reset mid-load aborts immediately. weights_ready stays 0 until a new full load.
- States: IDLE, ISSUE, WAIT, DONE, ERR.
- IDLE:
  - If start && conv_idle: clear loaded_mask, weights_ready and timeout_err; cur_filter=0; go to ISSUE.
  - start with conv_idle low is ignored, not queued.
- ISSUE (1 cycle):
  - rom_read_enable = one-hot(cur_filter), Moore output, high only in this cycle.
  - Clear wait counter; go to WAIT.
- WAIT:
  - Wait counter increments each cycle.
  - rom_weight_valid[cur_filter]=1: set loaded_mask[cur_filter]. If cur_filter==NUM_FILTERS-1 go to DONE; else cur_filter+1 and go to ISSUE.
  - Valid bits of other filters are ignored; they never set the mask.
  - Counter reaches TIMEOUT_CYCLES with no valid: go to ERR.
  - Valid and timeout in the same cycle: valid wins.
- DONE (1 cycle): done=1; weights_ready←1; go to IDLE.
- ERR (1 cycle): timeout_err←1; loaded_mask retains partial progress; weights_ready stays 0; go to IDLE.
- busy=1 in ISSUE, WAIT and DONE; 0 in IDLE and ERR.
- start while busy is ignored.
- conv_idle falling mid-load does not abort.
- weights_ready holds until the next accepted start or reset.
- Read pulses are never held for more than one cycle, so a ROM never restarts its read and overwrites its weight output register.
- Latency, ROM valid L cycles after its pulse:
  - Each filter takes L+1 cycles.
  - done occurs in cycle 1+NUM_FILTERS·(L+1), counting the cycle start is accepted as cycle 0.
- cur_filter is held after DONE/ERR until the next start.

Optional Feature:
- WLS_PARALLEL_EN defined:
  - ISSUE pulses all rom_read_enable bits simultaneously.
  - WAIT ORs every rom_weight_valid bit into loaded_mask.
  - DONE is entered when loaded_mask is all-ones, including the cycle the last bit arrives.
  - The timeout applies once to the whole batch; cur_filter stays 0.
  - Latency is L+2 cycles from acceptance to done.
- WLS_PARALLEL_EN undefined: sequential one-hot behaviour as above.

Test Plan:
- NUM_FILTERS=3, ROM model L=5; start=1, conv_idle=1 at cycle 0 →
  - rom_read_enable=001/010/100 at cycles 1/7/13;
  - loaded_mask=001,011,111 after cycles 6/12/18;
  - done pulse at cycle 19, weights_ready=1 from cycle 20.
- start with conv_idle=0 → no pulse, busy=0; then conv_idle=1 with start → load proceeds with the same timing offset.
- ROM 1 never asserts valid, TIMEOUT_CYCLES=64 →
  - ERR after 64 WAIT cycles; timeout_err=1, loaded_mask=001, weights_ready=0, no done.
  - A new start clears timeout_err.
- Spurious rom_weight_valid[2] while loading filter 0 → ignored, mask unchanged. start pulses mid-load → ignored, timing unchanged.
- rst_n low at cycle 10 of a load → all outputs 0 asynchronously; after release, IDLE and no pulses until a new start.
- With WLS_PARALLEL_EN defined, L=5, start at cycle 0 →
  - rom_read_enable=111 at cycle 1;
  - done at cycle 7;
  - staggered valids (ROM 2 at L=9) → done one cycle after the last valid.
